ctrl_interrupcoes: RTL and testbench

Parametrised N-channel interrupt controller with latched pending requests, per-channel mask, priority arbitration and an irq/ack handshake. It replaces the four-channel combinational priority-encoder-plus-mux arrangement wherever interrupts must be held until serviced rather than merely routed. It sits between the peripheral request lines and the processor's interrupt input, presenting one `irq` line and the winning channel `id`.

---
 rtl/ctrl_int_pkg.sv | 19 +
 rtl/codpri_n.sv | 42 ++++
 rtl/ctrl_interrupcoes.sv | 111 +++++++++++
 tb/tb_ctrl_interrupcoes.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_int_pkg.sv
// Shared definitions for the ctrl_interrupcoes interrupt controller:
// FSM state encoding and the supported channel-count range.
package ctrl_int_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SERVE = 2'b01;
    localparam logic [1:0] GAP   = 2'b10;

    // Supported range for the channel count N.
    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SERVE = SERVE,
        ST_GAP   = GAP
    } state_e;

endpackage

// File: rtl/codpri_n.sv
// Combinational N-input priority encoder: the highest set index wins.
// CTRL_INT_ROUND_ROBIN_EN adds a rotation offset so the search starts at off-1.
module codpri_n #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i,
    input  logic          en,
`ifdef CTRL_INT_ROUND_ROBIN_EN
    input  logic [IW-1:0] off,
`endif
    output logic [IW-1:0] y,
    output logic          valid
);

    logic [N-1:0] rot;

    always_comb begin
        rot   = '0;
        y     = '0;
        valid = 1'b0;
        for (int j = 0; j < N; j++) begin
`ifdef CTRL_INT_ROUND_ROBIN_EN
            // Position N-1 of rot maps to channel off-1, giving it top priority.
            rot[j] = i[(j + int'(off)) % N];
`else
            rot[j] = i[j];
`endif
        end
        for (int j = 0; j < N; j++) begin
            if (en && rot[j]) begin
                valid = 1'b1;
`ifdef CTRL_INT_ROUND_ROBIN_EN
                y     = IW'((j + int'(off)) % N);
`else
                y     = IW'(j);
`endif
            end
        end
    end

endmodule

// File: rtl/ctrl_interrupcoes.sv
// N-channel interrupt controller: edge-latched pending requests, mask, priority
// arbitration and irq/ack handshake. CTRL_INT_ROUND_ROBIN_EN selects round-robin.
module ctrl_interrupcoes
    import ctrl_int_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic          ack,
    output logic          irq,
    output logic [IW-1:0] id,
    output logic [N-1:0]  pending
);

    state_e        state_q, state_d;
    logic          irq_q, irq_d;
    logic [IW-1:0] id_q, id_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  req_prev_q;
    logic [N-1:0]  clr;
    logic [IW-1:0] win_id;
    logic          win_vld;

`ifdef CTRL_INT_ROUND_ROBIN_EN
    logic [IW-1:0] last_q, last_d;
`endif

    codpri_n #(.N(N), .IW(IW)) u_codpri (
        .i     (pending_q & ~mask),
        .en    (en),
`ifdef CTRL_INT_ROUND_ROBIN_EN
        .off   (last_q),
`endif
        .y     (win_id),
        .valid (win_vld)
    );

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        id_d    = id_q;
        clr     = '0;
`ifdef CTRL_INT_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    id_d    = win_id;
                    irq_d   = 1'b1;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (ack) begin
                    clr[id_q] = 1'b1;
                    irq_d     = 1'b0;
                    state_d   = ST_GAP;
`ifdef CTRL_INT_ROUND_ROBIN_EN
                    last_d    = id_q;
`endif
                end else if (!en) begin
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        // A fresh edge overrides the clear of the same channel.
        pending_d = (pending_q & ~clr) | (req & ~req_prev_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            irq_q      <= 1'b0;
            id_q       <= '0;
            pending_q  <= '0;
            req_prev_q <= '0;
`ifdef CTRL_INT_ROUND_ROBIN_EN
            last_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            id_q       <= id_d;
            pending_q  <= pending_d;
            req_prev_q <= req;
`ifdef CTRL_INT_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign irq     = irq_q;
    assign id      = id_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_ctrl_interrupcoes.sv
// Self-checking bench for ctrl_interrupcoes: directed literal checks followed by
// randomized stimulus compared every cycle against a behavioural model.
module tb_ctrl_interrupcoes;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          en;
    logic          ack;
    logic [N-1:0]  req;
    logic [N-1:0]  mask;
    logic          irq;
    logic [IW-1:0] id;
    logic [N-1:0]  pending;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Behavioural model state.
    bit           m_irq;
    bit           m_gap;
    int           m_id;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_prev;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_clr;
    int           w;
`ifdef CTRL_INT_ROUND_ROBIN_EN
    int           m_last;
`endif

    ctrl_interrupcoes #(.N(N)) dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .req     (req),
        .mask    (mask),
        .ack     (ack),
        .irq     (irq),
        .id      (id),
        .pending (pending)
    );

    always #5 clock = ~clock;

    function automatic int pick(input logic [N-1:0] cand);
        int idx;
        for (int k = 1; k <= N; k++) begin
`ifdef CTRL_INT_ROUND_ROBIN_EN
            idx = ((m_last - k) % N + N) % N;
`else
            idx = N - k;
`endif
            if (cand[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_irq  = 1'b0;
            m_gap  = 1'b0;
            m_id   = 0;
            m_pend = '0;
            m_prev = '0;
`ifdef CTRL_INT_ROUND_ROBIN_EN
            m_last = 0;
`endif
        end else begin
            m_rise = req & ~m_prev;
            m_clr  = '0;
            if (m_irq) begin
                if (ack) begin
                    m_clr[m_id] = 1'b1;
                    m_irq = 1'b0;
                    m_gap = 1'b1;
`ifdef CTRL_INT_ROUND_ROBIN_EN
                    m_last = m_id;
`endif
                end else if (!en) begin
                    m_irq = 1'b0;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (en) begin
                w = pick(m_pend & ~mask);
                if (w >= 0) begin
                    m_irq = 1'b1;
                    m_id  = w;
                end
            end
            m_pend = (m_pend & ~m_clr) | m_rise;
            m_prev = req;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            chk("irq", 32'(irq), 32'(m_irq));
            chk("id", 32'(id), 32'(m_id));
            chk("pending", 32'(pending), 32'(m_pend));
        end
    end

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(input string name, input logic e_irq, input logic [IW-1:0] e_id,
                       input logic [N-1:0] e_pend);
        chk({name, ".irq"}, 32'(irq), 32'(e_irq));
        chk({name, ".id"}, 32'(id), 32'(e_id));
        chk({name, ".pending"}, 32'(pending), 32'(e_pend));
        chk({name, ".model_irq"}, 32'(m_irq), 32'(e_irq));
        chk({name, ".model_id"}, 32'(m_id), 32'(e_id));
        chk({name, ".model_pending"}, 32'(m_pend), 32'(e_pend));
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; req = '0; mask = '0; ack = 1'b0;
        step(); check_en = 1'b1;
        step();
        lit("reset", 1'b0, 2'd0, 4'b0000);
        reset = 1'b0;

        // Single request on channel 2.
        en = 1'b1; req = 4'b0100;
        step(); lit("single_pend", 1'b0, 2'd0, 4'b0100);
        step(); lit("single_irq", 1'b1, 2'd2, 4'b0100);
        ack = 1'b1;
        step(); lit("single_ack", 1'b0, 2'd2, 4'b0000);
        ack = 1'b0;
        step(); lit("single_gap", 1'b0, 2'd2, 4'b0000);
        req = '0;
        step();

        // Priority with channel 3 masked.
        mask = 4'b1000; req = 4'b1010;
        step(); lit("mask_pend", 1'b0, 2'd2, 4'b1010);
        step(); lit("mask_win", 1'b1, 2'd1, 4'b1010);
        ack = 1'b1;
        step(); lit("mask_ack", 1'b0, 2'd1, 4'b1000);
        ack = 1'b0;
        step(); lit("mask_gap", 1'b0, 2'd1, 4'b1000);
        step(); lit("mask_hold", 1'b0, 2'd1, 4'b1000);
        mask = 4'b0000;
        step(); lit("unmask", 1'b1, 2'd3, 4'b1000);
        ack = 1'b1;
        step(); lit("unmask_ack", 1'b0, 2'd3, 4'b0000);
        ack = 1'b0; req = '0;
        step(); step();

        // New edge on the channel being acknowledged: set wins.
        req = 4'b0010;
        step();
        req = 4'b0000;
        step(); lit("sw_serve", 1'b1, 2'd1, 4'b0010);
        ack = 1'b1; req = 4'b0010;
        step(); lit("sw_ack", 1'b0, 2'd1, 4'b0010);
        ack = 1'b0;
        step(); lit("sw_gap", 1'b0, 2'd1, 4'b0010);
        step(); lit("sw_again", 1'b1, 2'd1, 4'b0010);
        ack = 1'b1;
        step(); lit("sw_done", 1'b0, 2'd1, 4'b0000);
        ack = 1'b0; req = '0;
        step(); step();

        // Abort through en, then reset during service.
        req = 4'b0100;
        step();
        req = 4'b0000;
        step(); lit("ab_serve", 1'b1, 2'd2, 4'b0100);
        en = 1'b0;
        step(); lit("abort", 1'b0, 2'd2, 4'b0100);
        en = 1'b1;
        step(); lit("ab_again", 1'b1, 2'd2, 4'b0100);
        reset = 1'b1;
        step(); lit("rst_serve", 1'b0, 2'd0, 4'b0000);
        reset = 1'b0;

        // Randomized traffic checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
            en    = ($urandom_range(0, 9) != 0);
            ack   = en && ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        check_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
